// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection between ID and EX, backed by a
// DEPTH-entry writeback history. Define FWD_STALL_CNT_EN to add stall/hit event counters.
module fwd_hazard_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned DEPTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    adv,
  input  logic                    ex_valid,
  input  logic [RA_W-1:0]         ex_rd,
  input  logic                    ex_is_load,
  input  logic [XLEN-1:0]         ex_res,
  input  logic                    ld_done,
  input  logic [XLEN-1:0]         ld_data,
  input  logic [NUM_SRC-1:0]      src_used,
  input  logic [NUM_SRC*RA_W-1:0] src_addr,
  input  logic [NUM_SRC*XLEN-1:0] src_id_val,
  output logic [NUM_SRC*XLEN-1:0] src_fwd_val,
  output logic [NUM_SRC-1:0]      src_fwd_hit,
  output logic                    stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             hit_cnt
`endif
);

  // History entries: index 0 is MEM, index k is k+1 stages past EX.
  logic            e_v_q    [DEPTH];
  logic [RA_W-1:0] e_rd_q   [DEPTH];
  logic            e_ld_q   [DEPTH];
  logic            e_rdy_q  [DEPTH];
  logic [XLEN-1:0] e_data_q [DEPTH];

  logic            e_v_d    [DEPTH];
  logic [RA_W-1:0] e_rd_d   [DEPTH];
  logic            e_ld_d   [DEPTH];
  logic            e_rdy_d  [DEPTH];
  logic [XLEN-1:0] e_data_d [DEPTH];

  logic            ld_cmp;
  logic            rdy0_eff;
  logic [XLEN-1:0] data0_eff;

  logic [NUM_SRC-1:0] src_haz;
  logic [RA_W-1:0]    cur_addr;
  logic               matched;

  // Load data is only ever accepted by a valid, still-pending load sitting in MEM.
  assign ld_cmp    = ld_done && e_v_q[0] && e_ld_q[0] && !e_rdy_q[0];
  assign rdy0_eff  = e_rdy_q[0] | ld_cmp;
  assign data0_eff = ld_cmp ? ld_data : e_data_q[0];

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      e_v_d[k]    = e_v_q[k];
      e_rd_d[k]   = e_rd_q[k];
      e_ld_d[k]   = e_ld_q[k];
      e_rdy_d[k]  = e_rdy_q[k];
      e_data_d[k] = e_data_q[k];
    end
    e_rdy_d[0]  = rdy0_eff;
    e_data_d[0] = data0_eff;

    if (adv) begin
      e_v_d[0]    = ex_valid && (ex_rd != '0);
      e_rd_d[0]   = ex_rd;
      e_ld_d[0]   = ex_is_load;
      e_rdy_d[0]  = !ex_is_load;
      e_data_d[0] = ex_res;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        e_v_d[k]  = e_v_q[k-1];
        e_rd_d[k] = e_rd_q[k-1];
        e_ld_d[k] = e_ld_q[k-1];
        // A load completing while MEM moves on carries its data with it.
        e_rdy_d[k]  = (k == 1) ? rdy0_eff : e_rdy_q[k-1];
        e_data_d[k] = (k == 1) ? data0_eff : e_data_q[k-1];
      end
    end

    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        e_v_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        e_v_q[k]    <= 1'b0;
        e_rd_q[k]   <= '0;
        e_ld_q[k]   <= 1'b0;
        e_rdy_q[k]  <= 1'b0;
        e_data_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        e_v_q[k]    <= e_v_d[k];
        e_rd_q[k]   <= e_rd_d[k];
        e_ld_q[k]   <= e_ld_d[k];
        e_rdy_q[k]  <= e_rdy_d[k];
        e_data_q[k] <= e_data_d[k];
      end
    end
  end

  // Per-source select: EX first, then history youngest-first. The first match decides,
  // so a pending producer masks any older ready one.
  always_comb begin
    src_fwd_val = src_id_val;
    src_fwd_hit = '0;
    src_haz     = '0;
    cur_addr    = '0;
    matched     = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cur_addr = src_addr[i*RA_W +: RA_W];
      matched  = 1'b0;
      if (src_used[i] && (cur_addr != '0)) begin
        if (ex_valid && (ex_rd == cur_addr)) begin
          matched = 1'b1;
          if (ex_is_load) begin
            src_haz[i] = 1'b1;
          end else begin
            src_fwd_hit[i]                = 1'b1;
            src_fwd_val[i*XLEN +: XLEN]   = ex_res;
          end
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!matched && e_v_q[k] && (e_rd_q[k] == cur_addr)) begin
            matched = 1'b1;
            if (e_rdy_q[k]) begin
              src_fwd_hit[i]              = 1'b1;
              src_fwd_val[i*XLEN +: XLEN] = e_data_q[k];
            end else if ((k == 0) && ld_cmp) begin
              src_fwd_hit[i]              = 1'b1;
              src_fwd_val[i*XLEN +: XLEN] = ld_data;
            end else begin
              src_haz[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign stall = |src_haz;

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      hit_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((|src_fwd_hit) && (hit_cnt_q != '1)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign hit_cnt   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;
  localparam int unsigned NSRC = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic                 adv;
  logic                 ex_valid;
  logic [RA_W-1:0]      ex_rd;
  logic                 ex_is_load;
  logic [XLEN-1:0]      ex_res;
  logic                 ld_done;
  logic [XLEN-1:0]      ld_data;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*RA_W-1:0] src_addr;
  logic [NSRC*XLEN-1:0] src_id_val;
  logic [NSRC*XLEN-1:0] src_fwd_val;
  logic [NSRC-1:0]      src_fwd_hit;
  logic                 stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]          stall_cnt;
  logic [31:0]          hit_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] Id0 = 32'hC0DE_0000;
  localparam logic [31:0] Id1 = 32'hC0DE_0001;
  localparam logic [31:0] Id2 = 32'hC0DE_0002;

  fwd_hazard_unit #(
    .XLEN    (XLEN),
    .RA_W    (RA_W),
    .NUM_SRC (NSRC),
    .DEPTH   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .adv         (adv),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_res      (ex_res),
    .ld_done     (ld_done),
    .ld_data     (ld_data),
    .src_used    (src_used),
    .src_addr    (src_addr),
    .src_id_val  (src_id_val),
    .src_fwd_val (src_fwd_val),
    .src_fwd_hit (src_fwd_hit),
    .stall       (stall)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .hit_cnt     (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fval(input int i);
    return src_fwd_val[i*XLEN +: XLEN];
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic used, input logic [RA_W-1:0] a);
    src_used[i]                = used;
    src_addr[i*RA_W +: RA_W]   = a;
  endtask

  task automatic push(input logic v, input logic [RA_W-1:0] rd, input logic ld,
                      input logic [31:0] res);
    ex_valid   = v;
    ex_rd      = rd;
    ex_is_load = ld;
    ex_res     = res;
    adv        = 1'b1;
    step();
    adv        = 1'b0;
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    adv        = 1'b0;
    ex_valid   = 1'b0;
    ex_rd      = '0;
    ex_is_load = 1'b0;
    ex_res     = '0;
    ld_done    = 1'b0;
    ld_data    = '0;
    src_used   = '0;
    src_addr   = '0;
    src_id_val = {Id2, Id1, Id0};

    // Reset state
    #2;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_hit", {29'd0, src_fwd_hit}, 32'd0);
    check_eq("rst_val0", fval(0), Id0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    set_src(0, 1'b1, 5'd5);
    settle();
    check_eq("empty_val0", fval(0), Id0);
    check_eq("empty_hit", {29'd0, src_fwd_hit}, 32'd0);

    // Back-to-back ALU from EX
    ex_valid = 1'b1; ex_rd = 5'd5; ex_is_load = 1'b0; ex_res = 32'h11;
    settle();
    check_eq("b2b_val0", fval(0), 32'h11);
    check_eq("b2b_hit", {29'd0, src_fwd_hit}, 32'h1);
    check_eq("b2b_stall", {31'd0, stall}, 32'd0);

    // Priority: e0=rd5/0x22, e1=rd5/0x44, EX rd5/0x33
    push(1'b1, 5'd5, 1'b0, 32'h44);
    push(1'b1, 5'd5, 1'b0, 32'h22);
    set_src(1, 1'b1, 5'd5);
    set_src(2, 1'b0, 5'd5);
    ex_valid = 1'b1; ex_rd = 5'd5; ex_res = 32'h33;
    settle();
    check_eq("prio_ex_val0", fval(0), 32'h33);
    check_eq("prio_ex_val1", fval(1), 32'h33);
    check_eq("prio_unused2", fval(2), Id2);
    check_eq("prio_ex_hit", {29'd0, src_fwd_hit}, 32'h3);
    ex_valid = 1'b0;
    settle();
    check_eq("prio_e0_val0", fval(0), 32'h22);
    check_eq("prio_e0_stall", {31'd0, stall}, 32'd0);

    // Oldest entry visible, then discarded
    do_flush();
    set_src(1, 1'b0, 5'd0);
    push(1'b1, 5'd6, 1'b0, 32'h66);
    push(1'b0, 5'd0, 1'b0, 32'h0);
    push(1'b0, 5'd0, 1'b0, 32'h0);
    set_src(0, 1'b1, 5'd6);
    settle();
    check_eq("e2_val0", fval(0), 32'h66);
    push(1'b0, 5'd0, 1'b0, 32'h0);
    settle();
    check_eq("e2_gone_val0", fval(0), Id0);
    check_eq("e2_gone_hit", {29'd0, src_fwd_hit}, 32'd0);

    // Load-use
    do_flush();
    set_src(0, 1'b1, 5'd7);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_is_load = 1'b1; ex_res = 32'hDEAD;
    settle();
    check_eq("lu_ex_stall", {31'd0, stall}, 32'd1);
    check_eq("lu_ex_val0", fval(0), Id0);
    check_eq("lu_ex_hit", {29'd0, src_fwd_hit}, 32'd0);
    push(1'b1, 5'd7, 1'b1, 32'hDEAD);
    settle();
    check_eq("lu_mem_stall", {31'd0, stall}, 32'd1);
    ld_done = 1'b1; ld_data = 32'hAB;
    settle();
    check_eq("lu_bypass_stall", {31'd0, stall}, 32'd0);
    check_eq("lu_bypass_val0", fval(0), 32'hAB);
    check_eq("lu_bypass_hit", {29'd0, src_fwd_hit}, 32'h1);
    push(1'b0, 5'd0, 1'b0, 32'h0);
    ld_done = 1'b0;
    settle();
    check_eq("lu_e1_val0", fval(0), 32'hAB);
    check_eq("lu_e1_stall", {31'd0, stall}, 32'd0);

    // Pending younger load masks the older ready result
    push(1'b1, 5'd7, 1'b1, 32'h0);
    settle();
    check_eq("mask_stall", {31'd0, stall}, 32'd1);
    check_eq("mask_val0", fval(0), Id0);
    // Unfinished load moved past MEM: ld_done no longer applies
    push(1'b0, 5'd0, 1'b0, 32'h0);
    ld_done = 1'b1; ld_data = 32'h55;
    settle();
    check_eq("stale_ld_stall", {31'd0, stall}, 32'd1);
    check_eq("stale_ld_val0", fval(0), Id0);
    ld_done = 1'b0;

    // x0 and immediate operands
    do_flush();
    set_src(0, 1'b1, 5'd0);
    ex_valid = 1'b1; ex_rd = 5'd0; ex_is_load = 1'b0; ex_res = 32'h99;
    settle();
    check_eq("x0_val0", fval(0), Id0);
    check_eq("x0_hit", {29'd0, src_fwd_hit}, 32'd0);
    ex_rd = 5'd9; ex_is_load = 1'b1;
    set_src(1, 1'b0, 5'd9);
    settle();
    check_eq("imm_stall", {31'd0, stall}, 32'd0);
    set_src(1, 1'b1, 5'd9);
    settle();
    check_eq("imm_used_stall", {31'd0, stall}, 32'd1);
    ex_valid = 1'b0; ex_is_load = 1'b0;
    set_src(1, 1'b0, 5'd0);

    // Flush clears the history, even with a simultaneous advance
    push(1'b1, 5'd3, 1'b0, 32'h33);
    push(1'b1, 5'd4, 1'b0, 32'h44);
    set_src(0, 1'b1, 5'd3);
    set_src(1, 1'b1, 5'd4);
    settle();
    check_eq("pre_flush_val0", fval(0), 32'h33);
    check_eq("pre_flush_val1", fval(1), 32'h44);
    ex_valid = 1'b1; ex_rd = 5'd3; ex_res = 32'h77; adv = 1'b1; flush = 1'b1;
    step();
    ex_valid = 1'b0; adv = 1'b0; flush = 1'b0;
    settle();
    check_eq("flush_val0", fval(0), Id0);
    check_eq("flush_val1", fval(1), Id1);
    check_eq("flush_hit", {29'd0, src_fwd_hit}, 32'd0);

    // Asynchronous reset while stalled
    set_src(1, 1'b0, 5'd0);
    set_src(0, 1'b1, 5'd7);
    push(1'b1, 5'd7, 1'b1, 32'h0);
    settle();
    check_eq("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    settle();
    check_eq("async_rst_stall", {31'd0, stall}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    settle();
    check_eq("post_rst_stall", {31'd0, stall}, 32'd0);
    check_eq("post_rst_val0", fval(0), Id0);

`ifdef FWD_STALL_CNT_EN
    check_eq("cnt_rst", stall_cnt, 32'd0);
    set_src(0, 1'b0, 5'd0);
    push(1'b1, 5'd7, 1'b1, 32'h0);
    set_src(0, 1'b1, 5'd7);
    repeat (4) step();
    set_src(0, 1'b0, 5'd0);
    step();
    check_eq("cnt_four", stall_cnt, 32'd4);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    step();
    release dut.stall_cnt_q;
    set_src(0, 1'b1, 5'd7);
    repeat (2) step();
    check_eq("cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational two-stage forwarder, sitting between ID and EX.
- Keeps its own DEPTH-entry in-flight writeback history: destination, result, load flag and ready bit per entry.
- For NUM_SRC source operands it selects the youngest matching producer, and raises a load-use stall when that producer's data is not yet available.
- Replaces the separate alu_rd/mem_rd taps with one shift-register scoreboard.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- NUM_SRC, 3, number of forwarded operands (rs1, rs2, store data).
- DEPTH, 3, history entries past EX (MEM, WB, post-WB).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all history entries.
- adv  in  1  pipeline advances this cycle; history shifts.
- ex_valid  in  1  EX holds a register-writing instruction.
- ex_rd  in  RA_W  EX destination.
- ex_is_load  in  1  EX instruction is a load (result not yet known).
- ex_res  in  XLEN  EX ALU result.
- ld_done  in  1  load data returned for the entry in MEM (entry 0).
- ld_data  in  XLEN  returned load data.
- src_used  in  NUM_SRC  per-source "operand is a register read" (0 for immediate).
- src_addr  in  NUM_SRC*RA_W  packed source register addresses.
- src_id_val  in  NUM_SRC*XLEN  packed register-file values from ID.
- src_fwd_val  out  NUM_SRC*XLEN  packed forwarded values.
- src_fwd_hit  out  NUM_SRC  source was forwarded (not from ID).
- stall  out  1  hold ID/IF and inject a bubble into EX.

Behaviour:
- Entry fields: v, rd, ld, rdy, data. Entry 0 is MEM, entry k is k+1 stages past EX.
- Reset (rst_n=0, async): all v=0, rdy=0, data=0. Outputs are combinational, so with no valid producers: stall=0, src_fwd_hit=0, src_fwd_val=src_id_val.
- adv=1 at posedge:
  - e[0] <= {ex_valid && ex_rd!=0, ex_rd, ex_is_load, !ex_is_load, ex_res}.
  - e[k] <= e[k-1]; the oldest entry is discarded.
  - adv=0: entries hold.
- Load completion:
  - ld_done=1 with e[0].v && e[0].ld && !e[0].rdy sets rdy=1 and data=ld_data.
  - If adv=1 in the same cycle, the completed values land in e[1].
  - ld_done against a non-load or invalid e[0] is ignored.
- Stall does not block history shifting. The pipeline feeds ex_valid=0 for the bubble.
- flush=1 at posedge clears all v. flush has priority over adv and ld_done.
- Forward select per source i, when src_used[i]=1 and src_addr[i]!=0, in priority order:
  - (a) EX: ex_valid && ex_rd==addr. If ex_is_load, hazard; else value=ex_res.
  - (b) e[0]..e[DEPTH-1], youngest first, first v && rd==addr wins.
    - If rdy: value=data.
    - Else if ld_done (only possible for e[0]): value=ld_data, same-cycle bypass.
    - Else: hazard.
  - No match: value=src_id_val[i], hit=0.
- Hazard on source i: hit=0, value=src_id_val[i]. A hazard never falls through to an older match.
- src_used[i]=0 or addr=0: pass-through, no hazard.
- stall = OR of hazards over all sources. No latency: all outputs are combinational from current inputs and state.
- Reset deasserted mid-operation: history restarts empty; stale producers are lost by design (the pipeline is also reset).

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits): saturating count of cycles with stall=1.
  - Reset to 0 by rst_n. Not cleared by flush. Holds at 0xFFFFFFFF.
  - Adds output hit_cnt (32 bits), same rules, incremented once per cycle in which any src_fwd_hit bit is set.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Back-to-back ALU: EX ex_rd=5, ex_res=0x11, src_addr[0]=5 -> src_fwd_val[0]=0x11, hit[0]=1, stall=0.
- Priority: e[0] rd=5 data=0x22 plus EX rd=5 res=0x33, source 5 -> 0x33. Without EX, e[1] rd=5 0x44 also present -> 0x22.
- Load-use: EX load rd=7, source 7 -> stall=1. Advance with ex_valid=0; next cycle e[0] not ready, ld_done=0 -> stall=1. Then ld_done=1 ld_data=0xAB -> stall=0, value=0xAB. After further adv, e[1] holds 0xAB.
- x0 and immediate: EX rd=0 res=0x99, source 0 -> pass-through. src_used=0 with addr matching a pending load -> stall=0.
- Flush: entries rd=3/4 valid, flush=1 -> next cycle sources 3/4 pass-through. Async rst_n low mid-stall -> stall=0 immediately.
- FWD_STALL_CNT_EN build: 4 stall cycles -> stall_cnt=4. Force the counter to 0xFFFFFFFF, stall again -> stays 0xFFFFFFFF.
